// File: rtl/vend_ctrl.sv
// Two-product vending controller: coin credit, selection, dispenser handshake, unit-by-unit change.
// Define VEND_CTRL_STATS_EN to add the SOLD_A/SOLD_B sales counters.
module vend_ctrl #(
  parameter int PRICE_A = 3,
  parameter int PRICE_B = 4,
  parameter int TIMEOUT = 200
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic [1:0] COIN,
  input  logic [1:0] SEL,
  input  logic       CANCEL,
  input  logic       DISP_BUSY,
  output logic       DRINK_OUT_A,
  output logic       DRINK_OUT_B,
  output logic       CHANGE_OUT,
  output logic       COIN_REJ,
  output logic [3:0] CREDIT,
`ifdef VEND_CTRL_STATS_EN
  output logic       BUSY,
  output logic [7:0] SOLD_A,
  output logic [7:0] SOLD_B
`else
  output logic       BUSY
`endif
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0] PRICE_A4 = 4'(PRICE_A);
  localparam logic [3:0] PRICE_B4 = 4'(PRICE_B);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    credit_q, credit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_b_q, sel_b_d;
  logic          drink_a_q, drink_a_d;
  logic          drink_b_q, drink_b_d;
  logic          change_q, change_d;
  logic          rej_q, rej_d;
  logic          busy_q, busy_d;

  logic          coin_valid;
  logic [3:0]    coin_val;
  logic [4:0]    coin_sum;
  logic          coin_fits;
  logic          sel_a_ok;
  logic          sel_b_ok;
  logic [3:0]    vend_price;

  // The 5-bit sum lets the overflow guard see totals above 15 without wrapping.
  assign coin_valid = (COIN == 2'b01) || (COIN == 2'b10);
  assign coin_val   = (COIN == 2'b10) ? 4'd2 : 4'd1;
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits  = coin_valid && (coin_sum <= 5'd15);
  assign sel_a_ok   = (SEL == 2'b01) && (credit_q >= PRICE_A4);
  assign sel_b_ok   = (SEL == 2'b10) && (credit_q >= PRICE_B4);
  assign vend_price = sel_b_q ? PRICE_B4 : PRICE_A4;

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    cnt_d     = cnt_q;
    sel_b_d   = sel_b_q;
    drink_a_d = 1'b0;
    drink_b_d = 1'b0;
    change_d  = 1'b0;
    rej_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coin_valid) begin
          credit_d = coin_val;
          cnt_d    = '0;
          state_d  = S_CREDIT;
        end
      end
      S_CREDIT: begin
        if (CANCEL) begin
          rej_d   = coin_valid;
          state_d = S_CHANGE;
        end else if (sel_a_ok || sel_b_ok) begin
          rej_d   = coin_valid;
          sel_b_d = sel_b_ok;
          state_d = S_VEND;
        end else if (coin_fits) begin
          credit_d = coin_sum[3:0];
          cnt_d    = '0;
        end else begin
          rej_d = coin_valid;
          if (cnt_q == TO_LAST) begin
            state_d = S_CHANGE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_VEND: begin
        rej_d = coin_valid;
        if (!DISP_BUSY) begin
          drink_a_d = !sel_b_q;
          drink_b_d = sel_b_q;
          credit_d  = credit_q - vend_price;
          state_d   = (credit_q == vend_price) ? S_IDLE : S_CHANGE;
        end
      end
      S_CHANGE: begin
        rej_d = coin_valid;
        if (credit_q != 4'd0) begin
          change_d = 1'b1;
          credit_d = credit_q - 4'd1;
          if (credit_q == 4'd1) begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      credit_q  <= 4'd0;
      cnt_q     <= '0;
      sel_b_q   <= 1'b0;
      drink_a_q <= 1'b0;
      drink_b_q <= 1'b0;
      change_q  <= 1'b0;
      rej_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      cnt_q     <= cnt_d;
      sel_b_q   <= sel_b_d;
      drink_a_q <= drink_a_d;
      drink_b_q <= drink_b_d;
      change_q  <= change_d;
      rej_q     <= rej_d;
      busy_q    <= busy_d;
    end
  end

  assign DRINK_OUT_A = drink_a_q;
  assign DRINK_OUT_B = drink_b_q;
  assign CHANGE_OUT  = change_q;
  assign COIN_REJ    = rej_q;
  assign CREDIT      = credit_q;
  assign BUSY        = busy_q;

`ifdef VEND_CTRL_STATS_EN
  logic [7:0] sold_a_q, sold_a_d;
  logic [7:0] sold_b_q, sold_b_d;

  // Counters advance on the same edge as the dispense pulse and wrap naturally.
  always_comb begin
    sold_a_d = sold_a_q + {7'd0, drink_a_d};
    sold_b_d = sold_b_q + {7'd0, drink_b_d};
  end

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      sold_a_q <= 8'd0;
      sold_b_q <= 8'd0;
    end else begin
      sold_a_q <= sold_a_d;
      sold_b_q <= sold_b_d;
    end
  end

  assign SOLD_A = sold_a_q;
  assign SOLD_B = sold_b_q;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: a transaction-level credit model queues expected outputs per edge,
// a negedge monitor pops and compares them. Honours VEND_CTRL_STATS_EN for the sales counters.
module tb_vend_ctrl;

  localparam int PA = 3;
  localparam int PB = 4;
  localparam int TO = 10;

  logic       CLK_IN = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] COIN = 2'b00;
  logic [1:0] SEL = 2'b00;
  logic       CANCEL = 1'b0;
  logic       DISP_BUSY = 1'b0;
  logic       DRINK_OUT_A, DRINK_OUT_B, CHANGE_OUT, COIN_REJ, BUSY;
  logic [3:0] CREDIT;
`ifdef VEND_CTRL_STATS_EN
  logic [7:0] SOLD_A, SOLD_B;
`endif

  typedef struct {
    int          cyc;
    logic [8:0]  outs;
    logic [15:0] sold;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc_count = 0;
  int   check_count = 0;
  int   err_count = 0;

  // Reference model: a credit session is either collecting coins, waiting to dispense, or paying out.
  int m_credit, m_vend, m_quiet, m_sold_a, m_sold_b;
  bit m_collecting, m_refunding;

  vend_ctrl #(.PRICE_A(PA), .PRICE_B(PB), .TIMEOUT(TO)) dut (
    .CLK_IN(CLK_IN), .RST(RST), .COIN(COIN), .SEL(SEL), .CANCEL(CANCEL), .DISP_BUSY(DISP_BUSY),
    .DRINK_OUT_A(DRINK_OUT_A), .DRINK_OUT_B(DRINK_OUT_B), .CHANGE_OUT(CHANGE_OUT),
    .COIN_REJ(COIN_REJ), .CREDIT(CREDIT),
`ifdef VEND_CTRL_STATS_EN
    .BUSY(BUSY), .SOLD_A(SOLD_A), .SOLD_B(SOLD_B)
`else
    .BUSY(BUSY)
`endif
  );

  always #5 CLK_IN = ~CLK_IN;

  always @(posedge CLK_IN) cyc_count <= cyc_count + 1;

  function automatic logic [8:0] dutOuts();
    return {DRINK_OUT_A, DRINK_OUT_B, CHANGE_OUT, COIN_REJ, BUSY, CREDIT};
  endfunction

  function automatic logic [15:0] dutSold();
`ifdef VEND_CTRL_STATS_EN
    return {SOLD_A, SOLD_B};
`else
    return 16'd0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_credit = 0; m_vend = 0; m_quiet = 0; m_sold_a = 0; m_sold_b = 0;
    m_collecting = 0; m_refunding = 0;
  endtask

  function automatic bit modelActive();
    return m_collecting || m_refunding || (m_vend != 0);
  endfunction

  task automatic modelStep(input logic [1:0] coin, input logic [1:0] sel, input logic cancel,
                           input logic busy, output exp_t e);
    int   cv;
    logic a, b, chg, rej;
    cv = (coin == 2'b01) ? 1 : (coin == 2'b10) ? 2 : 0;
    a = 1'b0; b = 1'b0; chg = 1'b0; rej = 1'b0;
    if (m_refunding) begin
      rej = (cv != 0);
      chg = 1'b1;
      m_credit--;
      if (m_credit == 0) m_refunding = 0;
    end else if (m_vend != 0) begin
      rej = (cv != 0);
      if (!busy) begin
        if (m_vend == 1) begin
          a = 1'b1; m_credit -= PA; m_sold_a = (m_sold_a + 1) % 256;
        end else begin
          b = 1'b1; m_credit -= PB; m_sold_b = (m_sold_b + 1) % 256;
        end
        m_vend = 0;
        m_refunding = (m_credit > 0);
      end
    end else if (!m_collecting) begin
      if (cv != 0) begin
        m_credit = cv; m_collecting = 1; m_quiet = 0;
      end
    end else if (cancel) begin
      rej = (cv != 0); m_collecting = 0; m_refunding = 1;
    end else if (sel == 2'b01 && m_credit >= PA) begin
      rej = (cv != 0); m_collecting = 0; m_vend = 1;
    end else if (sel == 2'b10 && m_credit >= PB) begin
      rej = (cv != 0); m_collecting = 0; m_vend = 2;
    end else if (cv != 0 && m_credit + cv <= 15) begin
      m_credit += cv; m_quiet = 0;
    end else begin
      rej = (cv != 0);
      if (m_quiet == TO - 1) begin
        m_collecting = 0; m_refunding = 1;
      end else begin
        m_quiet++;
      end
    end
    e.cyc  = cyc_count + 1;
    e.outs = {a, b, chg, rej, (m_refunding || m_vend != 0), 4'(m_credit)};
    e.sold = {8'(m_sold_a), 8'(m_sold_b)};
  endtask

  task automatic applyStimulus(input logic [1:0] coin, input logic [1:0] sel, input logic cancel,
                               input logic busy);
    exp_t e;
    @(posedge CLK_IN);
    #1;
    COIN = coin; SEL = sel; CANCEL = cancel; DISP_BUSY = busy;
    modelStep(coin, sel, cancel, busy, e);
    sb_q.push_back(e);
  endtask

  task automatic drainToIdle();
    for (int i = 0; i < 64 && modelActive(); i++) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  // Reset lands mid-cycle so its effect on the outputs is visible before any clock edge.
  task automatic doReset();
    @(negedge CLK_IN);
    #2;
    RST = 1'b1;
    COIN = 2'b00; SEL = 2'b00; CANCEL = 1'b0; DISP_BUSY = 1'b0;
    sb_q.delete();
    modelReset();
    #1;
    checkOutput("reset_outputs", {7'd0, dutOuts()}, 16'd0);
    checkOutput("reset_sold", dutSold(), 16'd0);
    @(negedge CLK_IN);
    #2;
    RST = 1'b0;
  endtask

  always @(negedge CLK_IN) begin
    if (!RST) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc_count) begin
        void'(sb_q.pop_front());
        check_count++;
        err_count++;
        $display("[TB] FAIL missed_expectation: got none, expected entry (t=%0t)", $time);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc_count) begin
        mon_e = sb_q.pop_front();
        checkOutput("outputs", {7'd0, dutOuts()}, {7'd0, mon_e.outs});
`ifdef VEND_CTRL_STATS_EN
        checkOutput("sold", dutSold(), mon_e.sold);
`endif
      end
    end
  end

  task automatic runRandom(input int cycles);
    logic [1:0] c, s;
    logic       k, bz;
    for (int n = 0; n < cycles; n++) begin
      if (n % 250 == 200) begin
        repeat (15) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
      end else begin
        c  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        s  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        k  = ($urandom_range(0, 19) == 0);
        bz = 1'($urandom_range(0, 1));
        applyStimulus(c, s, k, bz);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion (t=%0t)", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    doReset();

    $display("[TB] exact-price purchase of A");
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
    drainToIdle();

    $display("[TB] product B with dispenser busy, then change");
    repeat (3) applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b10, 1'b0, 1'b1);
    repeat (5) applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
    drainToIdle();

    $display("[TB] credit saturation at 15");
    repeat (7) applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0);
    drainToIdle();

    $display("[TB] insufficient selection, cancel with coin");
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b1, 1'b0);
    drainToIdle();

    $display("[TB] idle timeout refund");
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
    repeat (14) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    drainToIdle();

    $display("[TB] randomized traffic");
    runRandom(3000);
    drainToIdle();

    $display("[TB] reset during change");
    doReset();
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("pre_reset_change", {10'd0, CHANGE_OUT, BUSY, CREDIT}, {10'd0, 1'b1, 1'b1, 4'd3});
    doReset();

`ifdef VEND_CTRL_STATS_EN
    $display("[TB] sales counter wrap");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
      if (i == 254) begin
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        checkOutput("sold_a_255", {8'd0, SOLD_A}, 16'd255);
      end
    end
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("sold_a_wrap", {8'd0, SOLD_A}, 16'd0);
`endif

    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge CLK_IN);
    #1;
    checkOutput("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Two-product vending controller. It accumulates coin credit, accepts a product selection, waits for the dispenser, then pays change back one unit per cycle.
- It sequences the shared dispenser and change hopper for the lab vending system. It replaces the single-product seller FSM at top level.
- Coin encoding is the same as the existing coin acceptor: 2'b01 = 1 unit, 2'b10 = 2 units.

Parameters:
- PRICE_A, 3: price of product A in units (1..15).
- PRICE_B, 4: price of product B in units (1..15).
- TIMEOUT, 200: idle cycles in CREDIT before automatic refund (>=2).

Ports:
- CLK_IN  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- COIN  in  2  coin event: 01 = 1 unit, 10 = 2 units, 00/11 = no coin.
- SEL  in  2  selection: 01 = A, 10 = B, 00/11 = none.
- CANCEL  in  1  refund request.
- DISP_BUSY  in  1  dispenser not ready.
- DRINK_OUT_A  out  1  one-cycle dispense pulse, product A.
- DRINK_OUT_B  out  1  one-cycle dispense pulse, product B.
- CHANGE_OUT  out  1  one pulse per refunded unit.
- COIN_REJ  out  1  one-cycle pulse: coin not accepted, return it physically.
- CREDIT  out  4  current credit.
- BUSY  out  1  high in VEND or CHANGE.

Behaviour:
- Reset (RST=1, asynchronous): state IDLE, CREDIT=0, timeout counter 0. All outputs 0 in the same instant.
- Outputs:
  - All outputs are registered.
  - An input sampled at edge t is reflected at edge t+1 (latency 1).
  - Pulses last exactly one cycle.
- Inputs are synchronous; no debouncing is done here.
- States are IDLE, CREDIT, VEND, CHANGE (2-bit encoding, default branch goes to IDLE).
- IDLE:
  - Valid coin: CREDIT=value, go to CREDIT, clear timeout counter.
  - SEL and CANCEL are ignored.
- CREDIT:
  - Priority in one cycle is CANCEL > SEL > COIN.
  - CANCEL: go to CHANGE.
  - SEL A with CREDIT>=PRICE_A (same rule for B): latch the selection, go to VEND.
  - SEL with insufficient credit: ignored, stay in CREDIT.
  - Valid coin, no accepted CANCEL/SEL:
    - If CREDIT+value<=15: add the value and clear the timeout counter.
    - Otherwise: COIN_REJ pulse, CREDIT unchanged.
  - A valid coin in the same cycle as an accepted CANCEL or SEL gets COIN_REJ.
  - Timeout counter increments on every cycle without an accepted coin. On reaching TIMEOUT-1, go to CHANGE.
- VEND:
  - While DISP_BUSY=1: hold state and credit.
  - First cycle with DISP_BUSY=0: pulse DRINK_OUT_x for the latched product, CREDIT -= price. Go to CHANGE if the remainder is >0, else go to IDLE.
- CHANGE:
  - Each cycle: CHANGE_OUT=1, CREDIT -= 1.
  - When CREDIT reaches 0, go to IDLE.
  - N units of credit give exactly N consecutive CHANGE_OUT cycles.
- Any valid coin in VEND or CHANGE gets a COIN_REJ pulse. SEL and CANCEL are ignored there.
- Credit arithmetic is 4-bit unsigned; the design never wraps (saturation guard above, subtraction only when the operand is <= CREDIT).
- BUSY=1 exactly while state is VEND or CHANGE.
- Reset mid-vend or mid-change drops the credit with no refund; this is documented as operator-visible behaviour.

Optional Feature:
- Macro: VEND_CTRL_STATS_EN.
- When defined: adds outputs SOLD_A[7:0] and SOLD_B[7:0].
  - Each increments on its DRINK_OUT pulse and wraps 255 -> 0.
  - Both reset to 0 on RST.
- When undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- PRICE_A=3, PRICE_B=4. Coin 01, coin 10, SEL=01 with DISP_BUSY=0 -> CREDIT 1, then 3; one DRINK_OUT_A pulse; no CHANGE_OUT; back to IDLE with CREDIT=0.
- Coins 10,10,10 (CREDIT=6), SEL=10, DISP_BUSY=1 for 5 cycles -> no dispense while busy; DRINK_OUT_B one cycle after busy drops; then CHANGE_OUT for exactly 2 cycles; CREDIT 6 -> 2 -> 1 -> 0.
- Coins to CREDIT=14, then coin 10 -> COIN_REJ pulse, CREDIT stays 14. Then coin 01 -> CREDIT=15.
- CREDIT=2, SEL=01 -> ignored, stay in CREDIT. CANCEL together with coin 01 in the same cycle -> COIN_REJ; exactly 2 CHANGE_OUT cycles.
- TIMEOUT=10, one coin 10, no further activity -> CHANGE entered 10 cycles after the coin; 2 CHANGE_OUT pulses.
- RST asserted during CHANGE with CREDIT=3 -> CHANGE_OUT drops immediately, CREDIT=0, IDLE. With VEND_CTRL_STATS_EN: after 256 A sales, SOLD_A=0.
